seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised iterative radix-2 restoring divider for the ALU; successor to the unsigned quotient-only divider.
- Adds a signed/unsigned mode, a remainder output, divide-by-zero detection, a busy flag, and an asynchronous active-low reset.
- Accepts one operation per start pulse. Resolves one quotient bit per clock.
- Sits beside the multiplier in the ALU. The execute stage stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- COUNTER_WIDTH, 6, iteration counter width; must satisfy 2^COUNTER_WIDTH > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- dividend  input  WIDTH  numerator; sampled only on an accepted start.
- divider  input  WIDTH  denominator; sampled only on an accepted start.
- signedMode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- start  input  1  request; accepted on a rising edge when the block is not busy.
- quotient  output  WIDTH  result quotient, registered.
- remainder  output  WIDTH  result remainder, registered.
- divByZero  output  1  set when the accepted divider was 0.
- busy  output  1  high while an operation is in flight.
- ready  output  1  high while quotient/remainder/divByZero are valid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. quotient=0, remainder=0, divByZero=0, busy=0, ready=0, counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, start=1 at an edge:
  - Latch |dividend| and |divider| (absolute values only when signedMode=1), quotient sign = sign(dividend) XOR sign(divider), remainder sign = sign(dividend).
  - Clear the partial remainder. Set counter=WIDTH. ready=0, busy=1.
  - If divider==0: go to FIX with divByZero pending. Otherwise go to RUN.
- RUN, each edge:
  - Shift {partialRemainder, workDividend} left by 1.
  - If partialRemainder >= |divider|: subtract it and shift in quotient bit 1; else shift in 0.
  - Decrement counter. At counter==1 the transition goes to FIX.
  - Exactly WIDTH RUN cycles.
  - Partial remainder is WIDTH+1 bits wide so the shift cannot overflow.
- FIX, one edge:
  - Negate the quotient if quotient sign=1; negate the remainder if remainder sign=1 (signed mode only).
  - Write quotient, remainder and divByZero. busy=0, ready=1. Go to DONE.
- Divide by zero: quotient = all ones; remainder = the original dividend (unmodified); divByZero=1. No RUN cycles.
- Signed overflow: MIN / -1 produces quotient=MIN and remainder=0 via the normal two's-complement wrap. divByZero=0.
- Latency, start accepted at edge k:
  - Normal: ready visible after edge k+WIDTH+1.
  - Divide by zero: ready visible after edge k+1.
- DONE: outputs hold until the next accepted start. Results are never cleared except by reset.
- start while busy (RUN/FIX): ignored. Operands are not re-sampled.
- start in DONE: accepted. ready drops the following cycle (back-to-back operation).
- Operand changes while busy have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The next start behaves as after power-up.
- Invariant: busy and ready are never both 1.
- Remainder sign rule: the remainder always carries the dividend's sign (truncating division). Whenever divByZero=0, dividend = quotient*divider + remainder.

Test Plan:
- Unsigned 11/3, WIDTH=32: start one cycle -> busy for 33 cycles, then ready=1, quotient=3, remainder=2, divByZero=0. Repeat with 6/2 -> 3/0 and 9/2 -> 4/1.
- Signed (signedMode=1): -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). 7/-2 -> -3/1. Same bit patterns with signedMode=0 -> 0xFFFFFFF9/2 -> quotient 0x7FFFFFFC, remainder 1.
- Divide by zero: 1234/0 -> ready after 1 cycle, quotient=0xFFFFFFFF, remainder=1234, divByZero=1. Next 10/5 -> divByZero=0, quotient=2, remainder=0.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, divByZero=0.
- start held high and operands changed during busy: 100/7 -> result stays 14/2 after 33 cycles. A new start in DONE immediately begins the next operation.
- reset pulsed low mid-RUN (cycle 10): all outputs go to 0 asynchronously, before the next edge. A subsequent 11/3 completes correctly in 33 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, one quotient bit per clock.
// Supports signed (two's-complement, truncating) and unsigned operands.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   dividend   numerator, sampled on an accepted start
//   divider    denominator, sampled on an accepted start
//   signedMode 1 = signed operands, sampled with start
//   start      request, accepted at an edge while not busy (IDLE/DONE)
//   quotient   registered quotient
//   remainder  registered remainder (carries the dividend's sign)
//   divByZero  set when the accepted divider was zero
//   busy       operation in flight
//   ready      quotient/remainder/divByZero valid
module seq_divider #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned COUNTER_WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  input  logic             signedMode,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             busy,
  output logic             ready
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                   state, state_next;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [WIDTH:0]           partial;   // partial remainder, one extra bit
  logic [WIDTH-1:0]         work;      // shifting dividend / growing quotient
  logic [WIDTH-1:0]         divAbs;
  logic                     qSign;
  logic                     rSign;
  logic                     zeroPend;

  logic                     accept;
  logic                     dividendNeg;
  logic                     dividerNeg;
  logic                     dividerZero;
  logic [WIDTH:0]           shifted;
  logic                     subOk;

  always_comb begin
    accept      = start && ((state == IDLE) || (state == DONE));
    dividendNeg = signedMode && dividend[WIDTH-1];
    dividerNeg  = signedMode && divider[WIDTH-1];
    dividerZero = (divider == '0);
    shifted     = {partial[WIDTH-1:0], work[WIDTH-1]};
    subOk       = (shifted >= {1'b0, divAbs});
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = dividerZero ? FIX : RUN;
      RUN:        if (counter == COUNTER_WIDTH'(1)) state_next = FIX;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter   <= '0;
      partial   <= '0;
      work      <= '0;
      divAbs    <= '0;
      qSign     <= 1'b0;
      rSign     <= 1'b0;
      zeroPend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            counter  <= COUNTER_WIDTH'(WIDTH);
            partial  <= '0;
            divAbs   <= dividerNeg ? -divider : divider;
            qSign    <= dividendNeg ^ dividerNeg;
            rSign    <= dividendNeg;
            zeroPend <= dividerZero;
            // On divide-by-zero no iteration runs, so the work register keeps
            // the raw dividend to be returned as the remainder.
            work     <= dividerZero ? dividend : (dividendNeg ? -dividend : dividend);
            busy     <= 1'b1;
            ready    <= 1'b0;
          end
        end
        RUN: begin
          counter <= counter - COUNTER_WIDTH'(1);
          if (subOk) begin
            partial <= shifted - {1'b0, divAbs};
            work    <= {work[WIDTH-2:0], 1'b1};
          end else begin
            partial <= shifted;
            work    <= {work[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (zeroPend) begin
            quotient  <= '1;
            remainder <= work;
            divByZero <= 1'b1;
          end else begin
            quotient  <= qSign ? -work : work;
            remainder <= rSign ? -partial[WIDTH-1:0] : partial[WIDTH-1:0];
            divByZero <= 1'b0;
          end
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divider  = '0;
  logic        signedMode = 1'b0;
  logic        start = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;
  logic        busy;
  logic        ready;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32), .COUNTER_WIDTH(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .dividend   (dividend),
    .divider    (divider),
    .signedMode (signedMode),
    .start      (start),
    .quotient   (quotient),
    .remainder  (remainder),
    .divByZero  (divByZero),
    .busy       (busy),
    .ready      (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ready after the accepting edge; returns edges elapsed
  // and whether busy/ready were ever seen together.
  task automatic wait_ready(output int n, output bit both);
    n = 0;
    both = 0;
    while (!ready && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (busy && ready) both = 1;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sm, input logic [31:0] eq, input logic [31:0] er,
                        input logic ez, input int lat);
    int n;
    bit both;
    @(negedge clock);
    dividend = a; divider = b; signedMode = sm; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_ready(n, both);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, 32'(divByZero), 32'(ez));
    check({tag, "_excl"}, 32'({busy, both}), 32'd0);
  endtask

  initial begin
    int n;
    bit both;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", 32'(divByZero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Unsigned
    run_op("u11_3", 32'd11, 32'd3, 1'b0, 32'd3, 32'd2, 1'b0, 33);
    run_op("u6_2",  32'd6,  32'd2, 1'b0, 32'd3, 32'd0, 1'b0, 33);
    run_op("u9_2",  32'd9,  32'd2, 1'b0, 32'd4, 32'd1, 1'b0, 33);

    // Signed and same patterns unsigned
    run_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_op("uF9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);

    // Divide by zero, then recovery; negative dividend returned unmodified
    run_op("dz1234", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);
    run_op("u10_5",  32'd10, 32'd5, 1'b0, 32'd2, 32'd0, 1'b0, 33);
    run_op("dzneg",  32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);

    // Signed overflow
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);

    // start held high, operands changed while busy
    @(negedge clock);
    dividend = 32'd100; divider = 32'd7; signedMode = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    dividend = 32'd50; divider = 32'd3;
    wait_ready(n, both);
    check("hold_lat", 32'(n), 32'd33);
    check("hold_q", quotient, 32'd14);
    check("hold_r", remainder, 32'd2);
    check("hold_excl", 32'(both), 32'd0);
    // start still high in DONE: next operation begins at the next edge
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_ready", 32'(ready), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_qhold", quotient, 32'd14);
    wait_ready(n, both);
    check("b2b_lat", 32'(n), 32'd33);
    check("b2b_q", quotient, 32'd16);
    check("b2b_r", remainder, 32'd2);

    // Reset mid-RUN, asynchronous
    @(negedge clock);
    dividend = 32'd11; divider = 32'd3; signedMode = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_q", quotient, 32'd0);
    check("arst_r", remainder, 32'd0);
    check("arst_dbz", 32'(divByZero), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op("post_rst", 32'd11, 32'd3, 1'b0, 32'd3, 32'd2, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
